// File: rtl/ram512_loader.sv
// Loads a RAM512 from a low-byte-first byte stream, or zero-fills it with FILL.
// Define RAM512_LOADER_READBACK_EN to read back and compare every written word.
module ram512_loader #(
   parameter int          DEPTH = 512,
   parameter logic [15:0] FILL  = 16'h0000
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       start_clear_i,
   input  logic                       stream_start_i,
   input  logic                       stream_end_i,
   input  logic                       byte_valid_i,
   input  logic [7:0]                 byte_data_i,
   output logic                       byte_ready_o,
   output logic [15:0]                ram_in_o,
   output logic                       ram_load_o,
   output logic [$clog2(DEPTH)-1:0]   ram_address_o,
   input  logic [15:0]                ram_out_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [$clog2(DEPTH):0]     word_count_o,
   output logic                       overflow_o,
   output logic                       verify_err_o
);

   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LO,
      S_HI,
      S_WRITE,
`ifdef RAM512_LOADER_READBACK_EN
      S_VERIFY,
`endif
      S_FULL,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [AW-1:0]  ramAddr_q, ramAddr_d;
   logic [15:0]    ramData_q, ramData_d;
   logic           ramLoad_q, ramLoad_d;
   logic [7:0]     loByte_q, loByte_d;
   logic [AW:0]    wordCount_q, wordCount_d;
   logic           overflow_q, overflow_d;
   logic           endSeen_q, endSeen_d;
`ifdef RAM512_LOADER_READBACK_EN
   logic           clearMode_q, clearMode_d;
   logic           verifyErr_q, verifyErr_d;
`else
   logic           unusedRamOut;
`endif

   logic           xfer;
   logic           endEff;
   state_t         afterWrite;

   assign byte_ready_o  = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_FULL);
   assign xfer          = byte_valid_i && byte_ready_o;
   assign endEff        = stream_end_i || endSeen_q;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign ram_in_o      = ramData_q;
   assign ram_address_o = ramAddr_q;
   assign ram_load_o    = ramLoad_q;
   assign word_count_o  = wordCount_q;
   assign overflow_o    = overflow_q;
`ifdef RAM512_LOADER_READBACK_EN
   assign verify_err_o  = verifyErr_q;
`else
   assign verify_err_o  = 1'b0;
   assign unusedRamOut  = ^ram_out_i;
`endif

   // Next state; ramAddr_q/ramData_q only change when a new word is about to be written,
   // so the RAM ports hold the last written word while idle.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ramAddr_d   = ramAddr_q;
      ramData_d   = ramData_q;
      loByte_d    = loByte_q;
      wordCount_d = wordCount_q;
      overflow_d  = overflow_q;
      endSeen_d   = endSeen_q;
`ifdef RAM512_LOADER_READBACK_EN
      clearMode_d = clearMode_q;
      verifyErr_d = verifyErr_q;
`endif

      if (ramAddr_q == LAST_ADDR) begin
         afterWrite = S_FULL;
      end else if (endEff) begin
         afterWrite = S_DONE;
      end else begin
         afterWrite = S_LO;
      end

      case (state_q)
         S_IDLE: begin
            if (start_clear_i || stream_start_i) begin
               addr_d      = '0;
               wordCount_d = '0;
               overflow_d  = 1'b0;
               endSeen_d   = 1'b0;
`ifdef RAM512_LOADER_READBACK_EN
               verifyErr_d = 1'b0;
               clearMode_d = start_clear_i;
`endif
            end
            if (start_clear_i) begin
               state_d   = S_CLEAR;
               ramAddr_d = '0;
               ramData_d = FILL;
            end else if (stream_start_i) begin
               state_d = S_LO;
            end
         end

         S_CLEAR: begin
            wordCount_d = wordCount_q + 1'b1;
`ifdef RAM512_LOADER_READBACK_EN
            state_d = S_VERIFY;
`else
            if (ramAddr_q == LAST_ADDR) begin
               state_d = S_DONE;
            end else begin
               ramAddr_d = ramAddr_q + 1'b1;
            end
`endif
         end

         S_LO: begin
            endSeen_d = endSeen_q || stream_end_i;
            if (xfer) begin
               if (endEff) begin
                  // Last byte of an odd-length stream: write it straight away, high byte zero.
                  ramData_d = {8'h00, byte_data_i};
                  ramAddr_d = addr_q;
                  state_d   = S_WRITE;
               end else begin
                  loByte_d = byte_data_i;
                  state_d  = S_HI;
               end
            end else if (endEff) begin
               state_d = S_DONE;
            end
         end

         S_HI: begin
            endSeen_d = endSeen_q || stream_end_i;
            if (xfer) begin
               ramData_d = {byte_data_i, loByte_q};
               ramAddr_d = addr_q;
               state_d   = S_WRITE;
            end else if (endEff) begin
               ramData_d = {8'h00, loByte_q};
               ramAddr_d = addr_q;
               state_d   = S_WRITE;
            end
         end

         S_WRITE: begin
            endSeen_d   = endSeen_q || stream_end_i;
            wordCount_d = wordCount_q + 1'b1;
            addr_d      = addr_q + 1'b1;
`ifdef RAM512_LOADER_READBACK_EN
            state_d = S_VERIFY;
`else
            state_d = afterWrite;
`endif
         end

`ifdef RAM512_LOADER_READBACK_EN
         S_VERIFY: begin
            if (ram_out_i != ramData_q) begin
               verifyErr_d = 1'b1;
            end
            if (clearMode_q) begin
               if (ramAddr_q == LAST_ADDR) begin
                  state_d = S_DONE;
               end else begin
                  ramAddr_d = ramAddr_q + 1'b1;
                  state_d   = S_CLEAR;
               end
            end else begin
               endSeen_d = endSeen_q || stream_end_i;
               state_d   = afterWrite;
            end
         end
`endif

         S_FULL: begin
            endSeen_d = endSeen_q || stream_end_i;
            if (xfer) begin
               overflow_d = 1'b1;
            end
            if (endEff) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      ramLoad_d = (state_d == S_WRITE) || (state_d == S_CLEAR);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         ramAddr_q   <= '0;
         ramData_q   <= '0;
         ramLoad_q   <= 1'b0;
         loByte_q    <= '0;
         wordCount_q <= '0;
         overflow_q  <= 1'b0;
         endSeen_q   <= 1'b0;
`ifdef RAM512_LOADER_READBACK_EN
         clearMode_q <= 1'b0;
         verifyErr_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ramAddr_q   <= ramAddr_d;
         ramData_q   <= ramData_d;
         ramLoad_q   <= ramLoad_d;
         loByte_q    <= loByte_d;
         wordCount_q <= wordCount_d;
         overflow_q  <= overflow_d;
         endSeen_q   <= endSeen_d;
`ifdef RAM512_LOADER_READBACK_EN
         clearMode_q <= clearMode_d;
         verifyErr_q <= verifyErr_d;
`endif
      end
   end

endmodule

// File: tb/tb_ram512_loader.sv
// Bench for ram512_loader: RAM512 model, write scoreboard built from the byte stream,
// per-cycle compare process, and directed load/clear/overflow/reset scenarios.
module tb_ram512_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_clear = 1'b0;
   logic        stream_start = 1'b0;
   logic        stream_end = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic [15:0] ram_in;
   logic        ram_load;
   logic [8:0]  ram_address;
   logic [15:0] ram_out;
   logic        busy;
   logic        done;
   logic [9:0]  word_count;
   logic        overflow;
   logic        verify_err;

   always #5 clk = ~clk;

   ram512_loader dut (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .start_clear_i  (start_clear),
      .stream_start_i (stream_start),
      .stream_end_i   (stream_end),
      .byte_valid_i   (byte_valid),
      .byte_data_i    (byte_data),
      .byte_ready_o   (byte_ready),
      .ram_in_o       (ram_in),
      .ram_load_o     (ram_load),
      .ram_address_o  (ram_address),
      .ram_out_i      (ram_out),
      .busy_o         (busy),
      .done_o         (done),
      .word_count_o   (word_count),
      .overflow_o     (overflow),
      .verify_err_o   (verify_err)
   );

`ifdef RAM512_LOADER_READBACK_EN
   localparam int CLEAR_BUSY = 1024;
`else
   localparam int CLEAR_BUSY = 512;
`endif

   // RAM512: synchronous write, combinational read; preloadReq fills it with FFFF.
   logic [15:0] mem [0:511];
   logic        preloadReq = 1'b0;

   always @(posedge clk) begin
      if (preloadReq) begin
         for (int i = 0; i < 512; i++) mem[i] <= 16'hFFFF;
      end else if (ram_load) begin
         mem[ram_address] <= ram_in;
      end
   end

   assign ram_out = mem[ram_address];

   typedef struct packed {
      logic [8:0]  addr;
      logic [15:0] data;
   } wr_t;

   wr_t         expQ[$];
   logic [15:0] expMem [0:511];
   logic [7:0]  streamBytes [0:1099];
   int          expWords;
   logic        expOverflow;

   int   total = 0;
   int   bad = 0;
   int   doneCount = 0;
   int   busyCycles = 0;
   logic inClear = 1'b0;
   logic doneLast = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Words are byte pairs, low byte first; an odd tail is flushed with high byte 00 only
   // when the stream is ended; at most 512 words; any byte past byte 1024 is overflow.
   task automatic modelStream(input int n, input bit withEnd);
      int stored;
      logic [7:0] lo;
      logic [7:0] hi;
      stored = n / 2 + ((withEnd && (n % 2) != 0) ? 1 : 0);
      if (stored > 512) stored = 512;
      for (int k = 0; k < stored; k++) begin
         lo = streamBytes[2 * k];
         hi = (2 * k + 1 < n) ? streamBytes[2 * k + 1] : 8'h00;
         expQ.push_back({9'(k), hi, lo});
         expMem[k] = {hi, lo};
      end
      expWords    = stored;
      expOverflow = (n > 1024);
   endtask

   task automatic modelClear();
      for (int a = 0; a < 512; a++) begin
         expQ.push_back({9'(a), 16'h0000});
         expMem[a] = 16'h0000;
      end
      expWords    = 512;
      expOverflow = 1'b0;
   endtask

   // Compare process: every write against the scoreboard, plus per-cycle output rules.
   always @(negedge clk) begin
      wr_t e;
      if (!reset_n) begin
         checkOutput("resetOutputs", {26'd0, busy, done, ram_load, byte_ready, overflow, verify_err}, 32'd0);
      end else begin
         checkOutput("verifyErr", {31'd0, verify_err}, 32'd0);
         if (ram_load) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedWrite: got addr %0h data %0h, expected no write", ram_address, ram_in);
            end else begin
               e = expQ.pop_front();
               checkOutput("writeAddr", {23'd0, ram_address}, {23'd0, e.addr});
               checkOutput("writeData", {16'd0, ram_in}, {16'd0, e.data});
            end
         end
         if (done) begin
            doneCount++;
            checkOutput("loadInDone", {31'd0, ram_load}, 32'd0);
            checkOutput("doneWidth", {31'd0, doneLast}, 32'd0);
         end
         if (!busy) checkOutput("idleQuiet", {30'd0, byte_ready, ram_load}, 32'd0);
         if (inClear) checkOutput("readyInClear", {31'd0, byte_ready}, 32'd0);
         if (busy && !done) busyCycles++;
      end
      doneLast = done;
   end

   task automatic applyStimulus(input bit clr, input bit strm);
      @(negedge clk);
      start_clear  = clr;
      stream_start = strm;
      @(negedge clk);
      start_clear  = 1'b0;
      stream_start = 1'b0;
   endtask

   task automatic sendBytes(input int n);
      int i = 0;
      int guard = 0;
      logic take;
      while (i < n && guard < 20000) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_data  = streamBytes[i];
         take       = byte_ready;
         @(posedge clk);
         if (take) i++;
         guard++;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      checkOutput("bytesAccepted", i, n);
   endtask

   task automatic pulseEnd();
      @(negedge clk);
      stream_end = 1'b1;
      @(negedge clk);
      stream_end = 1'b0;
   endtask

   task automatic finishOp(input string name, input int budget, input int d0);
      int c = 0;
      while (done !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_doneTimeout: got no done after %0d cycles, expected done", name, budget);
      end
      repeat (2) @(negedge clk);
      checkOutput({name, "_wordCount"}, {22'd0, word_count}, expWords);
      checkOutput({name, "_overflow"}, {31'd0, overflow}, {31'd0, expOverflow});
      checkOutput({name, "_donePulses"}, doneCount - d0, 1);
      checkOutput({name, "_pendingWrites"}, expQ.size(), 0);
      checkOutput({name, "_busyAfter"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic checkMemory(input string name);
      int diffs = 0;
      for (int a = 0; a < 512; a++) begin
         if (mem[a] !== expMem[a]) diffs++;
      end
      checkOutput({name, "_memDiffs"}, diffs, 0);
   endtask

   task automatic preload();
      @(negedge clk);
      preloadReq = 1'b1;
      for (int a = 0; a < 512; a++) expMem[a] = 16'hFFFF;
      @(negedge clk);
      preloadReq = 1'b0;
   endtask

   initial begin
      int d0;

      // Reset state
      preload();
      checkOutput("rst_wordCount", {22'd0, word_count}, 32'd0);
      checkOutput("rst_ramAddress", {23'd0, ram_address}, 32'd0);
      checkOutput("rst_ramIn", {16'd0, ram_in}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Even stream
      $display("[TB] even stream");
      streamBytes[0] = 8'h34; streamBytes[1] = 8'h12;
      streamBytes[2] = 8'h78; streamBytes[3] = 8'h56;
      modelStream(4, 1'b1);
      d0 = doneCount;
      applyStimulus(1'b0, 1'b1);
      sendBytes(4);
      pulseEnd();
      finishOp("even", 200, d0);
      checkOutput("even_ram0", {16'd0, mem[0]}, 32'h1234);
      checkOutput("even_ram1", {16'd0, mem[1]}, 32'h5678);
      checkOutput("even_count2", {22'd0, word_count}, 32'd2);
      checkMemory("even");

      // Odd stream with flush
      $display("[TB] odd stream");
      streamBytes[0] = 8'hAB; streamBytes[1] = 8'hCD; streamBytes[2] = 8'hEF;
      modelStream(3, 1'b1);
      d0 = doneCount;
      applyStimulus(1'b0, 1'b1);
      sendBytes(3);
      pulseEnd();
      finishOp("odd", 200, d0);
      checkOutput("odd_ram0", {16'd0, mem[0]}, 32'hCDAB);
      checkOutput("odd_ram1", {16'd0, mem[1]}, 32'h00EF);
      checkOutput("odd_noOverflow", {31'd0, overflow}, 32'd0);
      checkMemory("odd");

      // Clear over a preloaded RAM
      $display("[TB] clear");
      preload();
      modelClear();
      d0 = doneCount;
      busyCycles = 0;
      applyStimulus(1'b1, 1'b0);
      finishOp("clear", 3000, d0);
      checkOutput("clear_busyCycles", busyCycles, CLEAR_BUSY);
      checkOutput("clear_ram511", {16'd0, mem[511]}, 32'h0000);
      checkMemory("clear");

      // 1026 bytes: RAM fills, last two bytes overflow
      $display("[TB] overflow stream");
      for (int i = 0; i < 1026; i++) streamBytes[i] = 8'(i * 7 + (i >> 8) * 3);
      modelStream(1026, 1'b1);
      d0 = doneCount;
      applyStimulus(1'b0, 1'b1);
      sendBytes(1026);
      pulseEnd();
      finishOp("full", 200, d0);
      checkOutput("full_ram0", {16'd0, mem[0]}, 32'h0700);
      checkOutput("full_ram511", {16'd0, mem[511]}, 32'h02FB);
      checkOutput("full_overflow", {31'd0, overflow}, 32'd1);
      checkOutput("full_count512", {22'd0, word_count}, 32'd512);
      checkMemory("full");

      // Reset after three words, then restart from address 0
      $display("[TB] reset mid-load");
      for (int i = 0; i < 7; i++) streamBytes[i] = 8'(8'h10 + i);
      modelStream(7, 1'b0);
      applyStimulus(1'b0, 1'b1);
      sendBytes(7);
      checkOutput("mid_pendingWrites", expQ.size(), 0);
      checkOutput("mid_wordCount", {22'd0, word_count}, 32'd3);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rstLoad", {31'd0, ram_load}, 32'd0);
      checkOutput("mid_rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rstReady", {31'd0, byte_ready}, 32'd0);
      checkOutput("mid_rstCount", {22'd0, word_count}, 32'd0);
      checkOutput("mid_rstAddr", {23'd0, ram_address}, 32'd0);
      checkOutput("mid_rstData", {16'd0, ram_in}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      streamBytes[0] = 8'hAA; streamBytes[1] = 8'hBB;
      modelStream(2, 1'b1);
      d0 = doneCount;
      applyStimulus(1'b0, 1'b1);
      sendBytes(2);
      pulseEnd();
      finishOp("restart", 200, d0);
      checkOutput("restart_ram0", {16'd0, mem[0]}, 32'hBBAA);
      checkOutput("restart_addrHeld", {23'd0, ram_address}, 32'd0);
      checkMemory("restart");

      // Clear and stream start together: clear wins, bytes and late starts ignored
      $display("[TB] clear priority");
      preload();
      modelClear();
      d0 = doneCount;
      busyCycles = 0;
      inClear = 1'b1;
      @(negedge clk);
      start_clear  = 1'b1;
      stream_start = 1'b1;
      byte_valid   = 1'b1;
      byte_data    = 8'h99;
      @(negedge clk);
      start_clear  = 1'b0;
      stream_start = 1'b0;
      repeat (20) @(negedge clk);
      stream_start = 1'b1;
      @(negedge clk);
      stream_start = 1'b0;
      finishOp("prio", 3000, d0);
      byte_valid = 1'b0;
      inClear    = 1'b0;
      checkOutput("prio_busyCycles", busyCycles, CLEAR_BUSY);
      checkMemory("prio");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL globalTimeout: got no completion, expected finish before 1000000");
      $fatal(1, "[TB] timeout");
   end

endmodule
